// File: rtl/seq_mult_div.sv
// Multicycle signed 32x32 multiply/divide unit for the execute stage.
// Multiply: radix-2 Booth over 32 steps. Divide: restoring division on
// magnitudes followed by a sign-fix pass. One shared 32-bit adder does
// every addition; results are announced by a one-cycle ready pulse.

// 32-bit carry-select adder built from four byte slices.
module four_byte_CSA (
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co,
  output logic        overflow
);
  logic [4:0] carry;

  assign carry[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      logic [8:0] sum0;
      logic [8:0] sum1;
      // Each byte precomputes both carry-in outcomes; the chain only selects.
      assign sum0 = {1'b0, in_a[gi*8 +: 8]} + {1'b0, in_b[gi*8 +: 8]};
      assign sum1 = sum0 + 9'd1;
      assign sum[gi*8 +: 8] = carry[gi] ? sum1[7:0] : sum0[7:0];
      assign carry[gi+1]    = carry[gi] ? sum1[8] : sum0[8];
    end
  endgenerate

  assign co       = carry[4];
  assign overflow = (in_a[31] == in_b[31]) && (sum[31] != in_a[31]);
endmodule

module seq_mult_div #(
  parameter bit DIV0_FAST = 1'b1,
  parameter int CNT_W     = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  typedef enum logic [2:0] {IDLE, MULT, DIV, SIGNFIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      a_reg, a_next;        // multiplicand, or raw dividend
  logic [31:0]      b_reg, b_next;        // raw divisor (multiplier lives in lo)
  logic [31:0]      hi_reg, hi_next;      // P[63:32] for multiply, R for divide
  logic [31:0]      lo_reg, lo_next;      // P[31:0] for multiply, Q for divide
  logic             q_m1_reg, q_m1_next;  // Booth bit q(-1)
  logic             sign_reg, sign_next;  // quotient sign
  logic [31:0]      result_reg, result_next;
  logic             exc_reg, exc_next;
  logic             rdy_reg, rdy_next;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_ci, add_co, add_ovf_unused;
  logic [31:0] booth_hi;
  logic [31:0] rem_shift;
  logic        start, last_iter, b_zero;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_iter = (cnt_reg == CNT_W'(32));
  assign b_zero    = (b_reg == 32'd0);
  // Remainder after shifting the {R, Q} pair left by one.
  assign rem_shift = {hi_reg[30:0], lo_reg[31]};
  // Booth pairs 01/10 take the adder sum; 00/11 keep the old high half.
  assign booth_hi  = (lo_reg[0] ^ q_m1_reg) ? add_sum : hi_reg;

  four_byte_CSA adder (
    .in_a     (add_a),
    .in_b     (add_b),
    .ci       (ci_wire_fix(add_ci)),
    .sum      (add_sum),
    .co       (add_co),
    .overflow (add_ovf_unused)
  );

  function automatic logic ci_wire_fix(input logic c);
    return c;
  endfunction

  // Adder operand selection for the current state.
  // The divisor is never converted to a magnitude explicitly: ~|B|+1 equals
  // ~B+1 for non-negative B and equals B itself for negative B.
  always_comb begin
    add_a  = hi_reg;
    add_b  = a_reg;
    add_ci = 1'b0;
    case (state_reg)
      MULT: begin
        add_a  = hi_reg;
        add_b  = (lo_reg[0] & ~q_m1_reg) ? ~a_reg : a_reg;
        add_ci = lo_reg[0] & ~q_m1_reg;
      end
      DIV: begin
        if (cnt_reg == '0) begin
          add_a  = a_reg[31] ? ~a_reg : a_reg;
          add_b  = 32'd0;
          add_ci = a_reg[31];
        end else begin
          add_a  = rem_shift;
          add_b  = b_reg[31] ? b_reg : ~b_reg;
          add_ci = ~b_reg[31];
        end
      end
      SIGNFIX: begin
        add_a  = sign_reg ? ~lo_reg : lo_reg;
        add_b  = 32'd0;
        add_ci = sign_reg;
      end
      default: ;
    endcase
  end

  // Next-state and datapath update; a start in any state restarts the unit.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    q_m1_next   = q_m1_reg;
    sign_next   = sign_reg;
    result_next = result_reg;
    exc_next    = exc_reg;
    rdy_next    = 1'b0;
    if (start) begin
      a_next      = data_operandA;
      b_next      = data_operandB;
      cnt_next    = '0;
      q_m1_next   = 1'b0;
      hi_next     = 32'd0;
      result_next = 32'd0;
      exc_next    = 1'b0;
      if (ctrl_MULT) begin
        state_next = MULT;
        lo_next    = data_operandB;
      end else begin
        state_next = DIV;
        lo_next    = 32'd0;
        sign_next  = data_operandA[31] ^ data_operandB[31];
      end
    end else begin
      case (state_reg)
        MULT: begin
          if (last_iter) begin
            result_next = lo_reg;
            exc_next    = ~((&hi_reg & lo_reg[31]) | (~|hi_reg & ~lo_reg[31]));
            state_next  = DONE;
          end else begin
            hi_next   = {booth_hi[31], booth_hi[31:1]};
            lo_next   = {booth_hi[0], lo_reg[31:1]};
            q_m1_next = lo_reg[0];
            cnt_next  = cnt_reg + CNT_W'(1);
          end
        end
        DIV: begin
          if (cnt_reg == '0) begin
            if (DIV0_FAST && b_zero) begin
              result_next = 32'd0;
              exc_next    = 1'b1;
              state_next  = DONE;
            end else begin
              lo_next  = add_sum;  // |A|
              hi_next  = 32'd0;
              cnt_next = CNT_W'(1);
            end
          end else begin
            if (add_co) begin
              hi_next = add_sum;
              lo_next = {lo_reg[30:0], 1'b1};
            end else begin
              hi_next = rem_shift;
              lo_next = {lo_reg[30:0], 1'b0};
            end
            if (last_iter) state_next = SIGNFIX;
            else           cnt_next   = cnt_reg + CNT_W'(1);
          end
        end
        SIGNFIX: begin
          if (b_zero) begin
            result_next = 32'd0;
            exc_next    = 1'b1;
          end else begin
            result_next = add_sum;
            // Only a positive quotient of magnitude 2^31 is unrepresentable.
            exc_next    = ~sign_reg & lo_reg[31];
          end
          state_next = DONE;
        end
        DONE: begin
          rdy_next   = 1'b1;
          state_next = IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and working registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      q_m1_reg   <= 1'b0;
      sign_reg   <= 1'b0;
      result_reg <= 32'd0;
      exc_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      q_m1_reg   <= q_m1_next;
      sign_reg   <= sign_next;
      result_reg <= result_next;
      exc_reg    <= exc_next;
      rdy_reg    <= rdy_next;
    end
  end

  assign data_result    = result_reg;
  assign data_exception = exc_reg;
  assign data_resultRDY = rdy_reg;
endmodule

// File: tb/tb_seq_mult_div.sv
// Bench for seq_mult_div: behavioural arithmetic model with latency
// countdown, per-cycle output comparison, directed and random operations.
module tb_seq_mult_div;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad = 0;

  seq_mult_div #(.DIV0_FAST(1'b1), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {exception, result}.
  function automatic logic [32:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic ovf;
    sa  = $signed({{32{a[31]}}, a});
    sb  = $signed({{32{b[31]}}, b});
    p   = sa * sb;
    ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    return {ovf, p[31:0]};
  endfunction

  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q;
    if (b == 32'd0) return {1'b1, 32'd0};
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    q  = sa / sb;
    return {(q > 64'sd2147483647), q[31:0]};
  endfunction

  // Behavioural model: result/exception appear one edge before the ready
  // pulse; multiply takes 34 edges, divide 35, fast divide-by-zero 2.
  logic        m_pend = 1'b0;
  int          m_left = 0;
  logic        m_rdy = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic        m_exc = 1'b0;
  logic [31:0] m_fin_res = 32'd0;
  logic        m_fin_exc = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pend <= 1'b0;
      m_left <= 0;
      m_rdy  <= 1'b0;
      m_res  <= 32'd0;
      m_exc  <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      m_pend <= 1'b1;
      m_rdy  <= 1'b0;
      m_res  <= 32'd0;
      m_exc  <= 1'b0;
      if (ctrl_MULT) begin
        {m_fin_exc, m_fin_res} <= ref_mult(data_operandA, data_operandB);
        m_left <= 34;
      end else begin
        {m_fin_exc, m_fin_res} <= ref_div(data_operandA, data_operandB);
        m_left <= (data_operandB == 32'd0) ? 2 : 35;
      end
    end else begin
      m_rdy <= 1'b0;
      if (m_pend) begin
        m_left <= m_left - 1;
        if (m_left == 2) begin
          m_res <= m_fin_res;
          m_exc <= m_fin_exc;
        end
        if (m_left == 1) begin
          m_rdy  <= 1'b1;
          m_pend <= 1'b0;
        end
      end
    end
  end

  // Every cycle the outputs must match the model.
  always @(negedge clock) begin
    chk("cycle_rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
    chk("cycle_result", data_result, m_res);
    chk("cycle_exception", {31'd0, data_exception}, {31'd0, m_exc});
  end

  task automatic fire(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #2;
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(posedge clock); #2;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string tag, output bit got, output int edges,
                          output logic [31:0] res, output logic exc);
    got = 1'b0; edges = -1; res = 32'd0; exc = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        got = 1'b1; edges = k; res = data_result; exc = data_exception;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_timeout: got no ready pulse in 80 cycles, required one", tag);
    end else begin
      $display("txn %s: result=%h exception=%b ready_after=E%0d", tag, res, exc, edges);
    end
  endtask

  task automatic directed(input string tag, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit chk_exc,
                          input logic exp_exc, input int exp_edges);
    bit got; int edges; logic [31:0] res; logic exc;
    fire(m, d, a, b);
    wait_rdy(tag, got, edges, res, exc);
    if (got) begin
      chk({tag, "_result"}, res, exp_res);
      if (chk_exc) chk({tag, "_exception"}, {31'd0, exc}, {31'd0, exp_exc});
      if (exp_edges >= 0) chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] sp [4];
    sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000;
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 40)) - 32'd20;
      2:       return sp[$urandom_range(0, 3)];
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  // Multiplicand 0x80000000 is excluded: its negation does not fit the
  // 32-bit Booth accumulator, so only in-range multiplicands are drawn.
  task automatic pick(output bit m, output bit d, output logic [31:0] a, output logic [31:0] b);
    m = 1'($urandom_range(0, 1));
    d = m ? ($urandom_range(0, 3) == 0) : 1'b1;
    a = rnd_operand();
    b = rnd_operand();
    if (m && a == 32'h8000_0000) a = 32'h8000_0001;
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got no completion, required end of stimulus");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit got; int edges; logic [31:0] res; logic exc; int npulse;
    bit m, d; logic [31:0] a, b;

    #1 reset = 1'b0;
    #1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    @(posedge clock); #2 reset = 1'b1;

    directed("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, 1'b0, 34);
    directed("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1, 34);
    directed("mul_m1x80", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 34);
    directed("div_-17/5", 1'b0, 1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFD, 1'b1, 1'b0, 35);
    directed("div_100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b1, 1'b0, 35);
    directed("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, 1'b1, 2);
    directed("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 35);
    directed("both_ctrl", 1'b1, 1'b1, 32'd6, 32'd2, 32'd12, 1'b1, 1'b0, 34);

    // Abort: multiply 3x4 restarted by divide 20/4 at E10.
    fire(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (8) @(posedge clock);
    directed("abort_div", 1'b0, 1'b1, 32'd20, 32'd4, 32'd5, 1'b1, 1'b0, 35);

    // Reset dropped at E15 of a divide.
    fire(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (15) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) npulse++;
    end
    chk("midreset_no_rdy", 32'(npulse), 32'd0);
    directed("mul_2x2", 1'b1, 1'b0, 32'd2, 32'd2, 32'd4, 1'b1, 1'b0, 34);

    // Reset while a result is held clears it at once.
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("heldreset_result", data_result, 32'd0);
    @(posedge clock); #2 reset = 1'b1;

    // Random operations, some aborted mid-flight by a new start.
    for (int i = 0; i < 30; i++) begin
      pick(m, d, a, b);
      if ($urandom_range(0, 4) == 0) begin
        fire(m, d, a, b);
        repeat ($urandom_range(1, 30)) @(posedge clock);
        pick(m, d, a, b);
      end
      fire(m, d, a, b);
      wait_rdy("random", got, edges, res, exc);
    end

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
